// File: rtl/als_spi_if.sv
// Pin and sample-feed bundle of the PmodALS emulator.
// The master side is the ADC reader and sample source.
interface als_spi_if #(
  parameter int DATA_BITS = 8
);
  logic                 scl;
  logic                 cs;
  logic                 sdo;
  logic                 sdo_oe;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 busy;
  logic                 frame_done;
  logic                 frame_abort;

  modport master (
    output scl,
    output cs,
    output sample,
    output sample_valid,
    input  sdo,
    input  sdo_oe,
    input  sample_ready,
    input  busy,
    input  frame_done,
    input  frame_abort
  );

  modport slave (
    input  scl,
    input  cs,
    input  sample,
    input  sample_valid,
    output sdo,
    output sdo_oe,
    output sample_ready,
    output busy,
    output frame_done,
    output frame_abort
  );
endinterface

// File: rtl/als_spi_responder.sv
// PmodALS ADC emulator: serialises one buffered sample per cs frame
// as {lead zeros, data MSB first, trail zeros} on sdo.
module als_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_ZEROS  = 3,
  parameter int DATA_BITS   = 8,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  als_spi_if.slave    bus
);

  localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int CW    = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] CNT_END  = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic                    scl_prev_q, scl_prev_d;
  logic                    cs_prev_q, cs_prev_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sdo_q, sdo_d;
  logic [DATA_BITS-1:0]    buf_q, buf_d;
  logic                    full_q, full_d;
  logic [DATA_BITS-1:0]    last_q, last_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  logic                    scl_s, cs_s;
  logic                    scl_rise, scl_fall;
  logic                    cs_rise, cs_fall;
  logic                    hs;
  logic [DATA_BITS-1:0]    frame_val;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign hs = bus.sample_valid & ~full_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
    scl_prev_d = scl_s;
    cs_prev_d  = cs_s;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    sdo_d     = sdo_q;
    buf_d     = buf_q;
    full_d    = full_q;
    last_d    = last_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    frame_val = full_q ? buf_q : last_q;

    // Only possible while empty, so it never collides with the load.
    if (hs) begin
      buf_d  = bus.sample;
      full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) begin
          last_d  = frame_val;
          shift_d = FRAME_BITS'(frame_val) << TRAIL;
          sdo_d   = shift_d[FRAME_BITS-1];
          cnt_d   = '0;
          state_d = SHIFT;
          if (full_q) begin
            full_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
          abort_d = (cnt_q < CNT_END);
        end else begin
          if (scl_rise && cnt_q != CNT_END) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == CNT_LAST);
          end
          if (scl_fall) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            sdo_d   = shift_q[FRAME_BITS-2];
          end
        end
      end
      default: begin
        state_d = IDLE;
        sdo_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      cs_sync_q  <= '1;
      scl_prev_q <= 1'b1;
      cs_prev_q  <= 1'b1;
      shift_q    <= '0;
      cnt_q      <= '0;
      sdo_q      <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      last_q     <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      cs_sync_q  <= cs_sync_d;
      scl_prev_q <= scl_prev_d;
      cs_prev_q  <= cs_prev_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sdo_q      <= sdo_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      last_q     <= last_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.sdo          = sdo_q;
  assign bus.sdo_oe       = (state_q == SHIFT);
  assign bus.busy         = (state_q == SHIFT);
  assign bus.sample_ready = ~full_q;
  assign bus.frame_done   = done_q;
  assign bus.frame_abort  = abort_q;

endmodule
